// File: rtl/nn_stream_deserializer.sv
// nn_stream_deserializer: gathers a valid/ready sample stream into one
// INPUT_SIZE-entry frame and presents it with a frame_valid/frame_ready handshake.
// Ports: clk, reset (async, active-high); in_data/in_valid/in_last/in_ready (sample
// stream); frame_data/frame_valid/frame_ready (frame output); err_short/err_long
// (one-cycle framing error pulses).
// Option: define DESER_PINGPONG_EN for two buffers (fill one while presenting the other).
module nn_stream_deserializer #(
    parameter int WIDTH      = 17,
    parameter int INPUT_SIZE = 32,
    parameter int CNT_W      = $clog2(INPUT_SIZE)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [WIDTH-1:0] in_data,
    input  logic                    in_valid,
    input  logic                    in_last,
    output logic                    in_ready,
    output logic signed [WIDTH-1:0] frame_data [0:INPUT_SIZE-1],
    output logic                    frame_valid,
    input  logic                    frame_ready,
    output logic                    err_short,
    output logic                    err_long
);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(INPUT_SIZE - 1);

    logic [CNT_W-1:0] idx_q, idx_d;
    logic             ready_q, ready_d;
    logic             valid_q, valid_d;
    logic             short_q, short_d;
    logic             long_q, long_d;
    logic             accept;
    logic             at_end;
    logic             handshake;

    assign accept    = in_valid & ready_q;
    assign at_end    = (idx_q == LAST_IDX);
    assign handshake = valid_q & frame_ready;

    assign in_ready    = ready_q;
    assign frame_valid = valid_q;
    assign err_short   = short_q;
    assign err_long    = long_q;

`ifdef DESER_PINGPONG_EN
    logic signed [WIDTH-1:0] buf_q [2][INPUT_SIZE];
    logic signed [WIDTH-1:0] buf_d [2][INPUT_SIZE];
    // fill_q selects the buffer being written; the other one is presented.
    logic fill_q, fill_d;
    // pend_q: fill buffer complete but the presented buffer is still held.
    logic pend_q, pend_d;

    always_comb begin
        buf_d   = buf_q;
        fill_d  = fill_q;
        pend_d  = pend_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        short_d = 1'b0;
        long_d  = 1'b0;
        if (handshake) begin
            for (int k = 0; k < INPUT_SIZE; k++) begin
                buf_d[~fill_q][k] = '0;
            end
            valid_d = 1'b0;
            if (pend_q) begin
                fill_d  = ~fill_q;
                valid_d = 1'b1;
                pend_d  = 1'b0;
            end
        end
        // accept never coincides with pend_q because in_ready = ~pend.
        if (accept) begin
            buf_d[fill_q][idx_q] = in_data;
            if (at_end || in_last) begin
                idx_d   = '0;
                short_d = in_last & ~at_end;
                long_d  = at_end & ~in_last;
                if (!valid_q || handshake) begin
                    fill_d  = ~fill_q;
                    valid_d = 1'b1;
                end else begin
                    pend_d = 1'b1;
                end
            end else begin
                idx_d = idx_q + CNT_W'(1);
            end
        end
        ready_d = ~pend_d;
    end

    always_comb begin
        for (int k = 0; k < INPUT_SIZE; k++) begin
            frame_data[k] = buf_q[~fill_q][k];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q   <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            short_q <= 1'b0;
            long_q  <= 1'b0;
            fill_q  <= 1'b0;
            pend_q  <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                for (int k = 0; k < INPUT_SIZE; k++) begin
                    buf_q[b][k] <= '0;
                end
            end
        end else begin
            idx_q   <= idx_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            short_q <= short_d;
            long_q  <= long_d;
            fill_q  <= fill_d;
            pend_q  <= pend_d;
            buf_q   <= buf_d;
        end
    end
`else
    typedef enum logic {FILL, PRESENT} state_t;

    state_t                  state_q, state_d;
    logic signed [WIDTH-1:0] buf_q [INPUT_SIZE];
    logic signed [WIDTH-1:0] buf_d [INPUT_SIZE];

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        idx_d   = idx_q;
        short_d = 1'b0;
        long_d  = 1'b0;
        unique case (state_q)
            FILL: begin
                if (accept) begin
                    buf_d[idx_q] = in_data;
                    if (at_end || in_last) begin
                        state_d = PRESENT;
                        short_d = in_last & ~at_end;
                        long_d  = at_end & ~in_last;
                    end else begin
                        idx_d = idx_q + CNT_W'(1);
                    end
                end
            end
            PRESENT: begin
                // Release clears the buffer so short frames read as zero-padded.
                if (frame_ready) begin
                    state_d = FILL;
                    idx_d   = '0;
                    for (int k = 0; k < INPUT_SIZE; k++) begin
                        buf_d[k] = '0;
                    end
                end
            end
            default: state_d = FILL;
        endcase
        ready_d = (state_d == FILL);
        valid_d = (state_d == PRESENT);
    end

    always_comb begin
        for (int k = 0; k < INPUT_SIZE; k++) begin
            frame_data[k] = buf_q[k];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FILL;
            idx_q   <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            short_q <= 1'b0;
            long_q  <= 1'b0;
            for (int k = 0; k < INPUT_SIZE; k++) begin
                buf_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            short_q <= short_d;
            long_q  <= long_d;
            buf_q   <= buf_d;
        end
    end
`endif
endmodule

// File: tb/tb_nn_stream_deserializer.sv
// tb_nn_stream_deserializer: directed scenarios for nn_stream_deserializer
// with hand-computed expected frames.
module tb_nn_stream_deserializer;
    localparam int W = 17;
    localparam int N = 32;

    logic                clk = 1'b0;
    logic                reset;
    logic signed [W-1:0] in_data;
    logic                in_valid;
    logic                in_last;
    logic                in_ready;
    logic signed [W-1:0] frame_data [0:N-1];
    logic                frame_valid;
    logic                frame_ready;
    logic                err_short;
    logic                err_long;

    logic signed [W-1:0] exp_f [0:N-1];
    int tests_run = 0;
    int fails = 0;
    int short_cnt = 0;
    int long_cnt = 0;

    nn_stream_deserializer #(.WIDTH(W), .INPUT_SIZE(N)) dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready),
        .frame_data(frame_data), .frame_valid(frame_valid),
        .frame_ready(frame_ready),
        .err_short(err_short), .err_long(err_long)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (err_short === 1'b1) short_cnt++;
        if (err_long === 1'b1) long_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired tests_run=%0d", tests_run);
        $fatal(1, "watchdog");
    end

    function automatic int first_diff();
        for (int k = 0; k < N; k++) begin
            if (frame_data[k] !== exp_f[k]) return k;
        end
        return -1;
    endfunction

    task automatic push(input logic signed [W-1:0] d, input logic l);
        int n = 0;
        in_data = d;
        in_valid = 1'b1;
        in_last = l;
        while (in_ready !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) begin
            tests_run++;
            fails++;
            $display("FAIL push_timeout in_ready=%b required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic release_frame();
        frame_ready = 1'b1;
        @(posedge clk); #1;
        frame_ready = 1'b0;
    endtask

    task automatic test_reset();
        int i;
        reset = 1'b1;
        in_data = '0;
        in_valid = 1'b0;
        in_last = 1'b0;
        frame_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL rst_in_ready got %b required 0", in_ready);
        end
        tests_run++;
        if (frame_valid !== 1'b0) begin
            fails++;
            $display("FAIL rst_frame_valid got %b required 0", frame_valid);
        end
        tests_run++;
        if ({err_short, err_long} !== 2'b00) begin
            fails++;
            $display("FAIL rst_errs got %b%b required 00", err_short, err_long);
        end
        for (int k = 0; k < N; k++) exp_f[k] = '0;
        i = first_diff();
        tests_run++;
        if (i >= 0) begin
            fails++;
            $display("FAIL rst_data[%0d] got %0d required 0", i, frame_data[i]);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL rst_release_ready got %b required 1", in_ready);
        end
    endtask

    task automatic test_full_frame();
        int i;
        int s0 = short_cnt;
        int l0 = long_cnt;
        for (int k = 0; k < N - 1; k++) push(W'(k + 1), 1'b0);
        tests_run++;
        if (frame_valid !== 1'b0) begin
            fails++;
            $display("FAIL full_early_valid got %b required 0", frame_valid);
        end
        push(W'(N), 1'b1);
        tests_run++;
        if (frame_valid !== 1'b1 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL full_present valid=%b ready=%b required 1 0",
                     frame_valid, in_ready);
        end
        for (int k = 0; k < N; k++) exp_f[k] = W'(k + 1);
        i = first_diff();
        tests_run++;
        if (i >= 0) begin
            fails++;
            $display("FAIL full_data[%0d] got %0d required %0d",
                     i, frame_data[i], exp_f[i]);
        end
        release_frame();
        tests_run++;
        if (frame_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL full_release valid=%b ready=%b required 0 1",
                     frame_valid, in_ready);
        end
        tests_run++;
        if (short_cnt != s0 || long_cnt != l0) begin
            fails++;
            $display("FAIL full_errs short=%0d long=%0d required 0 0",
                     short_cnt - s0, long_cnt - l0);
        end
    endtask

    task automatic test_short();
        int i;
        int s0 = short_cnt;
        logic signed [W-1:0] v [5];
        v[0] = -17'sd3;
        v[1] = 17'sd7;
        v[2] = 17'h1FFFF;
        v[3] = 17'sd2;
        v[4] = 17'sd9;
        for (int k = 0; k < 5; k++) push(v[k], k == 4);
        tests_run++;
        if (err_short !== 1'b1 || frame_valid !== 1'b1) begin
            fails++;
            $display("FAIL short_pulse err_short=%b valid=%b required 1 1",
                     err_short, frame_valid);
        end
        for (int k = 0; k < N; k++) exp_f[k] = (k < 5) ? v[k] : '0;
        i = first_diff();
        tests_run++;
        if (i >= 0) begin
            fails++;
            $display("FAIL short_data[%0d] got %0d required %0d",
                     i, frame_data[i], exp_f[i]);
        end
        release_frame();
        tests_run++;
        if (short_cnt - s0 != 1) begin
            fails++;
            $display("FAIL short_count got %0d required 1", short_cnt - s0);
        end
        for (int k = 0; k < N; k++) exp_f[k] = '0;
        i = first_diff();
        tests_run++;
        if (i >= 0) begin
            fails++;
            $display("FAIL short_clear[%0d] got %0d required 0", i, frame_data[i]);
        end
    endtask

    task automatic test_long();
        int i;
        int l0 = long_cnt;
        for (int k = 0; k < N; k++) push(W'(100 + k), 1'b0);
        tests_run++;
        if (err_long !== 1'b1 || frame_valid !== 1'b1) begin
            fails++;
            $display("FAIL long_pulse err_long=%b valid=%b required 1 1",
                     err_long, frame_valid);
        end
        for (int k = 0; k < N; k++) exp_f[k] = W'(100 + k);
        i = first_diff();
        tests_run++;
        if (i >= 0) begin
            fails++;
            $display("FAIL long_data[%0d] got %0d required %0d",
                     i, frame_data[i], exp_f[i]);
        end
        release_frame();
        tests_run++;
        if (long_cnt - l0 != 1) begin
            fails++;
            $display("FAIL long_count got %0d required 1", long_cnt - l0);
        end
        push(17'sd555, 1'b1);
        tests_run++;
        if (frame_data[0] !== 17'sd555 || err_short !== 1'b1) begin
            fails++;
            $display("FAIL long_next_entry0 got %0d short=%b required 555 1",
                     frame_data[0], err_short);
        end
        release_frame();
    endtask

    task automatic test_back_to_back();
        int i;
        for (int k = 0; k < N; k++) push(W'(200 + k), k == N - 1);
        in_data = 17'sd777;
        in_valid = 1'b1;
        in_last = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
        end
        tests_run++;
        if (in_ready !== 1'b0 || frame_valid !== 1'b1) begin
            fails++;
            $display("FAIL bp_hold ready=%b valid=%b required 0 1",
                     in_ready, frame_valid);
        end
        for (int k = 0; k < N; k++) exp_f[k] = W'(200 + k);
        i = first_diff();
        tests_run++;
        if (i >= 0) begin
            fails++;
            $display("FAIL bp_stable[%0d] got %0d required %0d",
                     i, frame_data[i], exp_f[i]);
        end
        frame_ready = 1'b1;
        @(posedge clk); #1;
        frame_ready = 1'b0;
        tests_run++;
        if (in_ready !== 1'b1 || frame_valid !== 1'b0) begin
            fails++;
            $display("FAIL bp_resume ready=%b valid=%b required 1 0",
                     in_ready, frame_valid);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 1; k < N; k++) push(W'(800 + k), k == N - 1);
        exp_f[0] = 17'sd777;
        for (int k = 1; k < N; k++) exp_f[k] = W'(800 + k);
        i = first_diff();
        tests_run++;
        if (i >= 0 || frame_valid !== 1'b1) begin
            fails++;
            $display("FAIL bp_next_frame idx=%0d valid=%b required -1 1",
                     i, frame_valid);
        end
        release_frame();
    endtask

    task automatic test_reset_mid();
        int i;
        int s0 = short_cnt;
        int l0 = long_cnt;
        for (int k = 0; k < 12; k++) push(W'(50 + k), 1'b0);
        #2;
        reset = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 1'b0 || frame_valid !== 1'b0) begin
            fails++;
            $display("FAIL mid_rst ready=%b valid=%b required 0 0",
                     in_ready, frame_valid);
        end
        for (int k = 0; k < N; k++) exp_f[k] = '0;
        i = first_diff();
        tests_run++;
        if (i >= 0) begin
            fails++;
            $display("FAIL mid_rst_data[%0d] got %0d required 0", i, frame_data[i]);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        for (int k = 0; k < N; k++) push(W'(300 + k), k == N - 1);
        for (int k = 0; k < N; k++) exp_f[k] = W'(300 + k);
        i = first_diff();
        tests_run++;
        if (i >= 0 || frame_valid !== 1'b1) begin
            fails++;
            $display("FAIL mid_rst_frame idx=%0d valid=%b required -1 1",
                     i, frame_valid);
        end
        release_frame();
        tests_run++;
        if (short_cnt != s0 || long_cnt != l0) begin
            fails++;
            $display("FAIL mid_rst_errs short=%0d long=%0d required 0 0",
                     short_cnt - s0, long_cnt - l0);
        end
    endtask

`ifdef DESER_PINGPONG_EN
    task automatic test_pingpong();
        int i;
        int drops = 0;
        frame_ready = 1'b1;
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < N; k++) begin
                if (in_ready !== 1'b1) drops++;
                push(W'(1000 * f + k), k == N - 1);
                if (k == N - 2) begin
                    tests_run++;
                    if (frame_valid !== 1'b0) begin
                        fails++;
                        $display("FAIL pp_early_valid f=%0d got %b required 0",
                                 f, frame_valid);
                    end
                end
            end
            for (int k = 0; k < N; k++) exp_f[k] = W'(1000 * f + k);
            i = first_diff();
            tests_run++;
            if (i >= 0 || frame_valid !== 1'b1) begin
                fails++;
                $display("FAIL pp_frame f=%0d idx=%0d valid=%b required -1 1",
                         f, i, frame_valid);
            end
        end
        tests_run++;
        if (drops != 0) begin
            fails++;
            $display("FAIL pp_ready_drops got %0d required 0", drops);
        end
        @(posedge clk); #1;
        frame_ready = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_full_frame();
        test_short();
        test_long();
        test_back_to_back();
        test_reset_mid();
`ifdef DESER_PINGPONG_EN
        test_pingpong();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule
